// File: rtl/gz_pkg.sv
// Shared types and constants for the Goertzel channel scheduler:
// FSM state encoding, output-word field offsets and width helpers.
package gz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESTART,
    ST_FEED,
    ST_WAIT_RES,
    ST_EMIT
  } gz_state_e;

  localparam int unsigned TD_W      = 128;
  localparam int unsigned TD_IM_LSB = 0;
  localparam int unsigned TD_RE_LSB = 16;
  localparam int unsigned TD_CH_LSB = 32;

  function automatic int unsigned gz_cw(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int unsigned gz_cntw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gz_channel_scheduler_if.sv
// Result stream from the scheduler to the capture buffer (valid/ready).
interface gz_channel_scheduler_if;
  import gz_pkg::*;

  logic [TD_W-1:0] tdata;
  logic            tvalid;
  logic            tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/gz_rr_arbiter.sv
// Combinational round-robin pick: first set mask bit strictly after
// i_ptr, wrapping; o_gvalid is low when the mask is empty.
module gz_rr_arbiter
  import gz_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = gz_cw(NCH)
) (
  input  logic [NCH-1:0] i_mask,
  input  logic [CW-1:0]  i_ptr,
  output logic [CW-1:0]  o_grant,
  output logic           o_gvalid
);

  always_comb begin : pick
    int unsigned     idx;
    logic [CW-1:0]   sel;
    o_grant  = '0;
    o_gvalid = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = (32'(i_ptr) + k) % NCH;
      sel = CW'(idx);
      if (!o_gvalid && i_mask[sel]) begin
        o_grant  = sel;
        o_gvalid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gz_channel_scheduler.sv
// Time-multiplexes one Goertzel engine over NCH ADC streams, one window per
// round-robin slot. Optional result-wait timeout: define GZS_TIMEOUT_EN.
module gz_channel_scheduler
  import gz_pkg::*;
#(
  parameter int unsigned IW  = 12,
  parameter int unsigned OW  = 20,
  parameter int unsigned SW  = 16,
  parameter int unsigned N   = 126,
  parameter int unsigned NCH = 4,
  parameter int unsigned TMO = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NCH*128-1:0]   s_axis_tdata,
  input  logic [NCH-1:0]       s_axis_tvalid,
  output logic [NCH-1:0]       s_axis_tready,
  input  logic                 run,
  input  logic [NCH-1:0]       ch_mask,
  output logic                 eng_rst,
  output logic                 eng_clken,
  output logic [IW-1:0]        eng_tdata,
  output logic                 eng_tvalid,
  input  logic [2*OW-1:0]      eng_res_tdata,
  input  logic                 eng_res_tvalid,
  output logic                 eng_res_tready,
  gz_channel_scheduler_if.master m_axis,
  output logic                 busy,
  output logic [gz_cw(NCH)-1:0] cur_ch,
  output logic                 err_timeout
);

  localparam int unsigned CW   = gz_cw(NCH);
  localparam int unsigned CNTW = gz_cntw(N);

  gz_state_e        r_state, w_state_nx;
  logic             r_clken, r_rst_phase;
  logic [CNTW-1:0]  r_cnt;
  logic [CW-1:0]    r_ptr, r_cur_ch;
  logic             r_eng_rst, r_eng_tvalid, r_res_tready, r_m_tvalid, r_busy;
  logic [IW-1:0]    r_eng_tdata;
  logic [TD_W-1:0]  r_m_tdata, w_m_word, w_beat;
  logic [CW-1:0]    w_grant;
  logic             w_gvalid, w_accept, w_capture, w_emit_done, w_timeout, w_tmo_hit;
  logic             w_unused;

  gz_rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .i_mask  (ch_mask),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_gvalid(w_gvalid)
  );

  always_comb begin
    w_beat = '0;
    for (int unsigned c = 0; c < NCH; c++)
      if (r_cur_ch == CW'(c)) w_beat = s_axis_tdata[c*128 +: 128];
  end

  always_comb begin
    w_m_word = '0;
    w_m_word[TD_CH_LSB +: CW] = r_cur_ch;
    w_m_word[TD_RE_LSB +: SW] = eng_res_tdata[2*OW-1 -: SW];
    w_m_word[TD_IM_LSB +: SW] = eng_res_tdata[OW-1 -: SW];
  end

  // Acceptance is decided while clken is low so the registered strobe
  // lands on the following clken-high cycle.
  always_comb begin
    w_state_nx  = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_emit_done = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:    if (run && w_gvalid) w_state_nx = ST_RESTART;
      ST_RESTART: if (r_rst_phase) w_state_nx = ST_FEED;
      ST_FEED: begin
        w_accept = !r_clken && s_axis_tvalid[r_cur_ch];
        if (w_accept && (r_cnt == CNTW'(N - 1))) w_state_nx = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (eng_res_tvalid) begin
          w_capture  = 1'b1;
          w_state_nx = ST_EMIT;
        end else if (w_tmo_hit) begin
          w_timeout  = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (m_axis.tready) begin
          w_emit_done = 1'b1;
          w_state_nx  = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ST_IDLE;
      r_clken      <= 1'b0;
      r_rst_phase  <= 1'b0;
      r_cnt        <= '0;
      r_ptr        <= CW'(NCH - 1);
      r_cur_ch     <= CW'(NCH - 1);
      r_eng_rst    <= 1'b0;
      r_eng_tvalid <= 1'b0;
      r_eng_tdata  <= '0;
      r_res_tready <= 1'b0;
      r_m_tvalid   <= 1'b0;
      r_m_tdata    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_clken      <= ~r_clken;
      r_rst_phase  <= (r_state == ST_RESTART) && !r_rst_phase;
      r_eng_rst    <= (w_state_nx == ST_RESTART);
      r_res_tready <= (w_state_nx == ST_WAIT_RES);
      r_m_tvalid   <= (w_state_nx == ST_EMIT);
      r_busy       <= (w_state_nx != ST_IDLE);
      r_eng_tvalid <= w_accept;
      if (w_accept) r_eng_tdata <= w_beat[16-IW +: IW];
      if (r_state == ST_RESTART) r_cnt <= '0;
      else if (w_accept)         r_cnt <= r_cnt + 1'b1;
      if ((r_state == ST_IDLE) && (w_state_nx == ST_RESTART)) r_cur_ch <= w_grant;
      if (w_capture) r_m_tdata <= w_m_word;
      if (w_emit_done || w_timeout) r_ptr <= r_cur_ch;
    end
  end

`ifdef GZS_TIMEOUT_EN
  localparam int unsigned TMOW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [TMOW-1:0] r_tmo_cnt;
  logic            r_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == ST_WAIT_RES) ? r_tmo_cnt + 1'b1 : '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign w_tmo_hit   = (r_tmo_cnt == TMOW'(TMO - 1));
  assign err_timeout = r_err;
  assign w_unused    = ^{s_axis_tdata, eng_res_tdata};
`else
  assign w_tmo_hit   = 1'b0;
  assign err_timeout = 1'b0;
  assign w_unused    = ^{s_axis_tdata, eng_res_tdata, TMO};
`endif

  assign s_axis_tready  = '1;
  assign eng_rst        = r_eng_rst;
  assign eng_clken      = r_clken;
  assign eng_tdata      = r_eng_tdata;
  assign eng_tvalid     = r_eng_tvalid;
  assign eng_res_tready = r_res_tready;
  assign m_axis.tdata   = r_m_tdata;
  assign m_axis.tvalid  = r_m_tvalid;
  assign busy           = r_busy;
  assign cur_ch         = r_cur_ch;

endmodule

// File: tb/tb_gz_channel_scheduler.sv
// Scoreboard bench for gz_channel_scheduler: ADC and engine models drive the
// DUT, expected beats are queued by the stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_gz_channel_scheduler;

  localparam int unsigned IW = 12, OW = 20, SW = 16, N = 126, NCH = 4;
`ifdef GZS_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 1024;
`endif
  localparam int BOUND = 4000;
  localparam logic [159:0] RST_VEC = 160'h6;  // all zero except cur_ch = 2'b11

  logic                aclk = 1'b0;
  logic                aresetn;
  logic [NCH*128-1:0]  s_axis_tdata;
  logic [NCH-1:0]      s_axis_tvalid, s_axis_tready;
  logic                run;
  logic [NCH-1:0]      ch_mask;
  logic                eng_rst, eng_clken, eng_tvalid;
  logic [IW-1:0]       eng_tdata;
  logic [2*OW-1:0]     eng_res_tdata;
  logic                eng_res_tvalid, eng_res_tready;
  logic                busy;
  logic [1:0]          cur_ch;
  logic                err_timeout;

  gz_channel_scheduler_if m_if ();

  gz_channel_scheduler #(.IW(IW), .OW(OW), .SW(SW), .N(N), .NCH(NCH), .TMO(TMO)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .run           (run),
    .ch_mask       (ch_mask),
    .eng_rst       (eng_rst),
    .eng_clken     (eng_clken),
    .eng_tdata     (eng_tdata),
    .eng_tvalid    (eng_tvalid),
    .eng_res_tdata (eng_res_tdata),
    .eng_res_tvalid(eng_res_tvalid),
    .eng_res_tready(eng_res_tready),
    .m_axis        (m_if),
    .busy          (busy),
    .cur_ch        (cur_ch),
    .err_timeout   (err_timeout)
  );

  always #5 aclk = ~aclk;

  int           checks = 0, errors = 0;
  logic [127:0] exp_q[$];
  int           feed_q[$];
  int           beats = 0, rst_events = 0, last_feed = 0, stray = 0;
  bit           respond_en = 1'b1, half_mode = 1'b0;
  logic [OW-1:0] res_re = 20'hABCDE, res_im = 20'h12345;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [159:0] out_vec();
    return 160'({eng_clken, eng_rst, eng_tvalid, eng_tdata, eng_res_tready,
                 m_if.tvalid, m_if.tdata, busy, cur_ch, err_timeout});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_beats(input int target, input string name);
    int t = 0;
    while (beats < target && t < BOUND) begin tick(1); t++; end
    if (beats < target) begin
      checks++; errors++;
      $display("FAIL %s_wait actual=%0d beats required=%0d", name, beats, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < BOUND) begin tick(1); t++; end
    check({name, "_idle"}, busy, 0);
  endtask

  // Serves n slots under mask, dropping run once the last slot has started.
  task automatic run_slots(input logic [NCH-1:0] mask, input int n, input string name);
    int b0 = beats;
    ch_mask = mask;
    run     = 1'b1;
    if (n > 1) wait_beats(b0 + n - 1, name);
    tick(3);
    run = 1'b0;
    wait_beats(b0 + n, name);
    wait_idle(name);
  endtask

  // ADC streams: lane-0 sample = {channel, sequence}, upper bits random.
  initial begin : adc
    int unsigned  seq[NCH];
    int unsigned  ph;
    logic [127:0] beat;
    ph = 0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '1;
    forever begin
      tick(1);
      ph++;
      for (int c = 0; c < NCH; c++) begin
        seq[c]++;
        beat = {$urandom(), $urandom(), $urandom(), $urandom()};
        beat[15:0] = {4'(c), 8'(seq[c]), 4'h5};
        s_axis_tdata[c*128 +: 128] = beat;
      end
      s_axis_tvalid = '1;
      if (half_mode) s_axis_tvalid[2] = ph[1];
    end
  end

  // Engine model: counts strobes per window, answers a few cycles into WAIT_RES.
  initial begin : eng
    bit prev_rst, prev_rdy, active, drive_now;
    int slot_ch, pulses, bad, feed_cyc, resp_cnt;
    prev_rst = 0; prev_rdy = 0; active = 0; drive_now = 0;
    slot_ch = -1; pulses = 0; bad = 0; feed_cyc = 0; resp_cnt = -1;
    eng_res_tvalid = 1'b0;
    eng_res_tdata  = '0;
    forever begin
      @(posedge aclk); #1;
      eng_res_tvalid = drive_now;
      if (drive_now) eng_res_tdata = {res_re, res_im};
      drive_now = 0;
      @(negedge aclk);
      if (!aresetn) begin
        active = 0; prev_rst = 0; prev_rdy = 0; resp_cnt = -1;
      end else begin
        if (eng_rst && !prev_rst) begin
          rst_events++;
          active = 1; pulses = 0; bad = 0; feed_cyc = 0;
          slot_ch = (feed_q.size() > 0) ? feed_q.pop_front() : -1;
        end
        if (active && !eng_rst && !eng_res_tready) feed_cyc++;
        if (eng_tvalid) begin
          if (!active) stray++;
          pulses++;
          if (!eng_clken || int'(eng_tdata[11:8]) != slot_ch) bad++;
        end
        if (eng_res_tready && !prev_rdy && active) begin
          check("eng_pulses", pulses, N);
          check("eng_samples_ok", bad, 0);
          last_feed = feed_cyc;
          active    = 0;
          resp_cnt  = 2;
        end else if (resp_cnt > 0) begin
          resp_cnt--;
        end else if (resp_cnt == 0) begin
          drive_now = respond_en;
          resp_cnt  = -1;
        end
        prev_rst = eng_rst;
        prev_rdy = eng_res_tready;
      end
    end
  end

  initial begin : mon
    logic [127:0] e;
    forever begin
      @(negedge aclk);
      if (aresetn && m_if.tvalid && m_if.tready) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          check("m_axis_tdata", m_if.tdata, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int           ord_ch[6]  = '{0, 1, 3, 0, 1, 3};
    logic [127:0] ord_exp[6] = '{128'h0_ABCD_1234, 128'h1_ABCD_1234, 128'h3_ABCD_1234,
                                 128'h0_ABCD_1234, 128'h1_ABCD_1234, 128'h3_ABCD_1234};
    logic [127:0] snap;
    int           n, b0, r0, stalls;

    aresetn = 1'b0; run = 1'b0; ch_mask = '0; m_if.tready = 1'b1;
    tick(3);
    check("reset_outputs", out_vec(), RST_VEC);
    check("s_axis_tready", s_axis_tready, 4'hF);
    aresetn = 1'b1;
    @(negedge aclk); check("clken_first", eng_clken, 0);
    @(negedge aclk); check("clken_second", eng_clken, 1);
    tick(1);

    // Round-robin order from reset over mask 1011
    for (int i = 0; i < 6; i++) begin
      feed_q.push_back(ord_ch[i]);
      exp_q.push_back(ord_exp[i]);
    end
    run_slots(4'b1011, 6, "order");

    // Single channel 0, continuous valid
    feed_q.push_back(0);
    exp_q.push_back(128'h0_ABCD_1234);
    run_slots(4'b0001, 1, "single");
    check_range("single_feed_len", last_feed, 2*N - 1, 2*N + 1);

    // Truncation boundary on channel 1
    res_re = 20'h8000F; res_im = 20'hFFFFF;
    feed_q.push_back(1);
    exp_q.push_back(128'h1_8000_FFFF);
    run_slots(4'b0010, 1, "trunc");

    // Reset mid-FEED: a ch2 slot is killed, ch0 is served first afterwards
    res_re = 20'h13579; res_im = 20'h2468A;
    feed_q.push_back(2);
    ch_mask = 4'b1111; run = 1'b1;
    tick(50);
    aresetn = 1'b0;
    #1;
    check("reset_mid_feed", out_vec(), RST_VEC);
    run = 1'b0;
    tick(3);
    aresetn = 1'b1;
    tick(2);
    feed_q.push_back(0);
    exp_q.push_back(128'h0_1357_2468);
    run_slots(4'b1111, 1, "post_reset");

    // Channel 2 with gapped valid: window stretches, still N samples
    half_mode = 1'b1;
    feed_q.push_back(2);
    exp_q.push_back(128'h2_1357_2468);
    run_slots(4'b0100, 1, "gapped");
    check_range("gapped_feed_len", last_feed, 3*N, 5*N);
    half_mode = 1'b0;

    // Backpressure in EMIT with run held high
    feed_q.push_back(3);
    exp_q.push_back(128'h3_1357_2468);
    m_if.tready = 1'b0;
    ch_mask = 4'b1000; run = 1'b1;
    n = 0;
    while (!m_if.tvalid && n < BOUND) begin @(negedge aclk); n++; end
    check("stall_tvalid", m_if.tvalid, 1);
    snap = m_if.tdata; r0 = rst_events; stalls = 0;
    repeat (50) begin
      @(negedge aclk);
      if (m_if.tdata !== snap || !busy || !m_if.tvalid) stalls++;
    end
    check("stall_stable", stalls, 0);
    check("stall_no_new_slot", rst_events - r0, 0);
    tick(1);
    run = 1'b0;
    b0 = beats;
    m_if.tready = 1'b1;
    tick(20);
    check("stall_single_beat", beats - b0, 1);
    check("stall_idle", busy, 0);

`ifdef GZS_TIMEOUT_EN
    // Engine silent on ch0: timeout, no beat, then ch1 served
    respond_en = 1'b0;
    feed_q.push_back(0);
    feed_q.push_back(1);
    exp_q.push_back(128'h1_1357_2468);
    b0 = beats;
    ch_mask = 4'b0011; run = 1'b1;
    n = 0;
    while (!eng_res_tready && n < BOUND) begin @(negedge aclk); n++; end
    n = 0;
    while (!err_timeout && n < 100) begin @(negedge aclk); n++; end
    check("timeout_latency", n, TMO);
    respond_en = 1'b1;
    tick(3);
    run = 1'b0;
    wait_beats(b0 + 1, "timeout_next");
    wait_idle("timeout_next");
    check("timeout_beats", beats - b0, 1);
    check("timeout_sticky", err_timeout, 1);
`else
    check("err_timeout_tied", err_timeout, 0);
`endif

    tick(5);
    check("stray_pulses", stray, 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
